// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO and runtime frame format.
// Optional parity bit compiled in with UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLOCK_RATE     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int CYCLES_PER_BIT = (CLOCK_RATE / BAUD_RATE) - 1,
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_write,
  output logic                          o_ready,
  input  logic [1:0]                    i_nbits,
  input  logic [1:0]                    i_parity,
  input  logic                          i_two_stop,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (CYCLES_PER_BIT > 0) ?
                      $clog2(CYCLES_PER_BIT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr, rd_ptr, level;
  logic [DATA_BITS-1:0] head;
  logic push, pop, load, fin, tick;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] n_q, n_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic two_q, two_d;
  logic tx_q, tx_d;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_parity;
  assign unused_parity = ^i_parity;
`endif

  function automatic logic [3:0] len_of(
    input logic [1:0] sel
  );
    logic [3:0] r;
    unique case (sel)
      2'd0:    r = 4'd5;
      2'd1:    r = 4'd6;
      2'd2:    r = 4'd7;
      default: r = 4'(DATA_BITS);
    endcase
    return r;
  endfunction

  function automatic logic [DATA_BITS-1:0] mask_of(
    input logic [3:0] n
  );
    logic [DATA_BITS-1:0] m;
    for (int i = 0; i < DATA_BITS; i++)
      m[i] = (i < int'(n));
    return m;
  endfunction

  assign level   = wr_ptr - rd_ptr;
  assign o_level = level;
  assign o_ready = (level != LW'(FIFO_DEPTH));
  assign push    = i_write & o_ready;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign o_busy  = (state_q != IDLE) | (level != '0);
  assign o_tx    = tx_q;
  assign tick    = (cnt_q == CW'(CYCLES_PER_BIT));
  assign pop     = load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    n_d     = n_q;
    shift_d = shift_q;
    two_d   = two_q;
    load    = 1'b0;
    fin     = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    if (state_q != IDLE)
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    unique case (state_q)
      IDLE:  load = (level != '0);
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == n_q - 4'd1) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP1;
`else
            state_d = STOP1;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PARITY: if (tick) state_d = STOP1;
      STOP1: begin
        if (tick) begin
          if (two_q) state_d = STOP2;
          else       fin = 1'b1;
        end
      end
      STOP2:   if (tick) fin = 1'b1;
      default: state_d = IDLE;
    endcase
    // Last stop bit chains straight into the next start bit
    if (fin) begin
      if (level != '0) load = 1'b1;
      else             state_d = IDLE;
    end
    if (load) begin
      state_d = START;
      shift_d = head;
      n_d     = len_of(i_nbits);
      two_d   = i_two_stop;
      idx_d   = '0;
      cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = (i_parity == 2'd1) |
                  (i_parity == 2'd2);
      par_bit_d = ^(head & mask_of(len_of(i_nbits)))
                  ^ (i_parity == 2'd2);
`endif
    end
    unique case (state_d)
      START: tx_d = 1'b0;
      DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_bit_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      shift_q <= '0;
      two_q   <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      two_q   <= two_d;
      tx_q    <= tx_d;
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model plus directed frames.
// Parity expectations follow UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int CPB   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data = '0;
  logic       write = 1'b0;
  logic [1:0] nbits = 2'd3;
  logic [1:0] parity = 2'd0;
  logic       two_stop = 1'b0;
  logic       ready, busy, tx;
  logic [3:0] level;

  uart_tx_fifo #(
    .CLOCK_RATE(16),
    .BAUD_RATE(1),
    .DATA_BITS(8),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_data(data),
    .i_write(write),
    .o_ready(ready),
    .i_nbits(nbits),
    .i_parity(parity),
    .i_two_stop(two_stop),
    .o_busy(busy),
    .o_level(level),
    .o_tx(tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Model: FIFO of words, and a queue of line levels per clock
  logic [7:0] mq[$];
  bit         lq[$];
  bit         exp_tx = 1'b1;
  bit         in_frame = 1'b0;
  bit         chk_en = 1'b0;
  int         m_pre;
  bit         m_wr;

  function automatic void push_bit(input bit b);
    for (int k = 0; k < CPB; k++) lq.push_back(b);
  endfunction

  function automatic void push_frame(input logic [7:0] w);
    int nb;
    bit p;
    nb = (nbits == 2'd0) ? 5 : (nbits == 2'd1) ? 6 :
         (nbits == 2'd2) ? 7 : 8;
    push_bit(1'b0);
    for (int j = 0; j < nb; j++) push_bit(w[j]);
`ifdef UART_TX_PARITY_EN
    if (parity == 2'd1 || parity == 2'd2) begin
      p = 1'b0;
      for (int j = 0; j < nb; j++) p ^= w[j];
      if (parity == 2'd2) p = ~p;
      push_bit(p);
    end
`else
    p = 1'b0;
`endif
    push_bit(1'b1);
    if (two_stop) push_bit(1'b1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      lq.delete();
      exp_tx = 1'b1;
      in_frame = 1'b0;
    end else begin
      m_pre = mq.size();
      m_wr = write && (m_pre < DEPTH);
      if (lq.size() == 0 && m_pre > 0)
        push_frame(mq.pop_front());
      if (lq.size() > 0) begin
        exp_tx = lq.pop_front();
        in_frame = 1'b1;
      end else begin
        exp_tx = 1'b1;
        in_frame = 1'b0;
      end
      if (m_wr) mq.push_back(data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_tx", tx, exp_tx);
      chk("cyc_level", level, mq.size());
      chk("cyc_ready", ready, mq.size() < DEPTH);
      chk("cyc_busy", busy,
          in_frame || (mq.size() > 0));
    end
  end

  bit samp[$];
  int rdy_idx;
  int fall_n;

  task automatic wr(input logic [7:0] d);
    data = d;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_fall();
    fall_n = 0;
    while (tx !== 1'b0 && fall_n < 40) begin
      @(negedge clk);
      fall_n++;
    end
    chk("tx_fall", tx, 0);
  endtask

  task automatic capture(input int maxc);
    int n;
    n = 0;
    rdy_idx = -1;
    samp.delete();
    while (busy === 1'b1 && n < maxc) begin
      samp.push_back(tx);
      if (ready === 1'b1 && rdy_idx < 0) rdy_idx = n;
      n++;
      @(negedge clk);
    end
    chk("capture_bound", int'(n < maxc), 1);
  endtask

  function automatic bit mid(input int k);
    return samp[CPB * k + CPB / 2];
  endfunction

  logic [9:0] g10;
  logic [7:0] g8;
  logic [7:0] word;

  initial begin
    #3 rst_n = 1'b0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    repeat (100) @(negedge clk);
    chk("idle_tx", tx, 1);
    chk("idle_busy", busy, 0);
    chk("idle_ready", ready, 1);
    chk("idle_level", level, 0);

    nbits = 2'd3; parity = 2'd0; two_stop = 1'b0;
    wr(8'hA5);
    chk("a5_level_after_wr", level, 1);
    wait_fall();
    chk("a5_fall_latency", fall_n, 1);
    capture(1000);
    chk("a5_len", samp.size(), 160);
    for (int k = 0; k < 10; k++) g10[k] = mid(k);
    chk("a5_line", g10, 10'b1101001010);
    chk("a5_busy_after", busy, 0);

    for (int pm = 1; pm <= 2; pm++) begin
      parity = 2'(pm);
      wr(8'h35);
      wait_fall();
      capture(1000);
`ifdef UART_TX_PARITY_EN
      chk("par_len", samp.size(), 176);
      chk("par_bit", mid(9), pm - 1);
`else
      chk("par_len", samp.size(), 160);
      chk("par_bit9_stop", mid(9), 1);
`endif
    end
    parity = 2'd0;

    nbits = 2'd0; two_stop = 1'b1;
    wr(8'h1F);
    wait_fall();
    capture(1000);
    chk("n5s2_len", samp.size(), 128);
    for (int k = 0; k < 8; k++) g8[k] = mid(k);
    chk("n5s2_line", g8, 8'b11111110);

    nbits = 2'd3; two_stop = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      data = 8'hC0 + 8'(i * 7);
      write = 1'b1;
      @(negedge clk);
    end
    write = 1'b0;
    chk("burst_full_level", level, 8);
    chk("burst_full_ready", ready, 0);
    capture(3000);
    chk("burst_len", samp.size(), 1432);
    chk("burst_first_free", rdy_idx, 152);
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 8; j++)
        word[j] = samp[160 * k + 16 * (j + 1)];
      chk("burst_word", word, 8'hC0 + 8'(k * 7));
    end

    wr(8'h52);
    wait_fall();
    repeat (72) @(negedge clk);
    chk("rst_pre_bit3", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_async", tx, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_level", level, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
